// File: rtl/mem_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// mem_ctrl_pkg
// Shared definitions for the memory access scheduler:
//   - DATA_W / ADDR_W : data and address widths of the memory interface
//   - ENTRY_W         : width of one request-queue entry
//   - state_t         : scheduler FSM encoding
//   - req_entry_t     : queue-entry field layout {write, addr, wdata}
// ---------------------------------------------------------------------------
package mem_ctrl_pkg;

  localparam int DATA_W  = 8;
  localparam int ADDR_W  = 8;
  localparam int ENTRY_W = 1 + ADDR_W + DATA_W;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  // Bit 16 = write flag, bits 15:8 = address, bits 7:0 = write data.
  typedef struct packed {
    logic              write;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } req_entry_t;

endpackage

// File: rtl/req_queue.sv
// ---------------------------------------------------------------------------
// req_queue
// Synchronous FIFO holding pending memory requests.
// The head entry is presented combinationally on dout so the consumer can
// pop and capture it on the same edge.
// Ports:
//   clk    : rising-edge clock
//   rst_n  : asynchronous active-low reset (clears pointers and count)
//   push   : write din at the tail (ignored when full)
//   din    : entry to enqueue
//   pop    : drop the head entry (ignored when empty)
//   dout   : current head entry
//   count  : number of stored entries, 0..DEPTH
//   full   : count == DEPTH
// ---------------------------------------------------------------------------
module req_queue
  import mem_ctrl_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int W     = ENTRY_W
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [W-1:0]               din,
  input  logic                       pop,
  output logic [W-1:0]               dout,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [W-1:0]     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [PTR_W:0]   count_reg;
  logic             do_push;
  logic             do_pop;

  assign full    = (count_reg == (PTR_W + 1)'(DEPTH));
  assign do_push = push && !full;
  assign do_pop  = pop && (count_reg != '0);
  assign dout    = mem[rd_ptr_reg];
  assign count   = count_reg;

  // Storage carries no reset so it can map onto distributed RAM.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr_reg] <= din;
    end
  end

  // DEPTH is a power of two, so pointer increment wraps naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + (PTR_W + 1)'(1);
        2'b01:   count_reg <= count_reg - (PTR_W + 1)'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/mem_access_scheduler.sv
// ---------------------------------------------------------------------------
// mem_access_scheduler
// Queues read/write requests and issues them one at a time, in acceptance
// order, to a memory controller. Reads wait RD_LAT cycles for data and then
// present a response held until the downstream handshake.
// Ports:
//   clk_mem      : rising-edge clock
//   reset        : asynchronous active-low reset
//   req_valid    : upstream request valid
//   req_ready    : queue can accept a request
//   req_write    : 1 = write, 0 = read
//   req_addr     : target address
//   req_wdata    : write data (ignored for reads)
//   w_en / r_en  : one-cycle write / read strobes to the controller
//   write_data   : data to the controller
//   read_address : address to the controller (reads and writes)
//   read_data    : data returned by the controller
//   rsp_valid    : read response valid
//   rsp_ready    : downstream accepts response
//   rsp_data     : read response data
//   busy         : queue non-empty or FSM not idle
// ---------------------------------------------------------------------------
module mem_access_scheduler
  import mem_ctrl_pkg::*;
#(
  parameter int QDEPTH = 4,
  parameter int RD_LAT = 1
) (
  input  logic              clk_mem,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              w_en,
  output logic              r_en,
  output logic [DATA_W-1:0] write_data,
  output logic [ADDR_W-1:0] read_address,
  input  logic [DATA_W-1:0] read_data,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              busy
);

  localparam int CNT_W = $clog2(QDEPTH) + 1;
  // At least one bit even when RD_LAT is zero.
  localparam int LAT_W = (RD_LAT < 1) ? 1 : $clog2(RD_LAT + 1);

  state_t           state_reg;
  req_entry_t       cmd_reg;
  logic [LAT_W-1:0] lat_cnt_reg;

  req_entry_t       q_din;
  logic [ENTRY_W-1:0] q_dout;
  logic [CNT_W-1:0] q_count;
  logic             q_full;
  logic             q_push;
  logic             q_pop;
  logic             q_empty;

  assign q_din.write = req_write;
  assign q_din.addr  = req_addr;
  assign q_din.wdata = req_wdata;

  // Ready depends only on the registered count: a full queue stays
  // unready even on the cycle the FSM pops.
  assign req_ready = ~q_full;
  assign q_push    = req_valid & req_ready;
  assign q_empty   = (q_count == '0);
  assign q_pop     = (state_reg == ST_IDLE) && !q_empty;
  assign busy      = !q_empty || (state_reg != ST_IDLE);

  req_queue #(
    .DEPTH (QDEPTH),
    .W     (ENTRY_W)
  ) u_req_queue (
    .clk   (clk_mem),
    .rst_n (reset),
    .push  (q_push),
    .din   (q_din),
    .pop   (q_pop),
    .dout  (q_dout),
    .count (q_count),
    .full  (q_full)
  );

  // Strobes are registered: the ISSUE-state edge raises w_en/r_en, so the
  // strobe is visible in the cycle after that edge and cleared at the next.
  // read_address/write_data only change on issue, holding otherwise.
  always_ff @(posedge clk_mem or negedge reset) begin
    if (!reset) begin
      state_reg    <= ST_IDLE;
      cmd_reg      <= '0;
      lat_cnt_reg  <= '0;
      w_en         <= 1'b0;
      r_en         <= 1'b0;
      write_data   <= '0;
      read_address <= '0;
      rsp_valid    <= 1'b0;
      rsp_data     <= '0;
    end else begin
      w_en <= 1'b0;
      r_en <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (!q_empty) begin
            cmd_reg   <= req_entry_t'(q_dout);
            state_reg <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          read_address <= cmd_reg.addr;
          write_data   <= cmd_reg.wdata;
          if (cmd_reg.write) begin
            w_en      <= 1'b1;
            state_reg <= ST_IDLE;
          end else begin
            r_en        <= 1'b1;
            lat_cnt_reg <= '0;
            state_reg   <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          // The first WAIT edge is the one ending the r_en cycle; data is
          // sampled RD_LAT edges after that.
          if (lat_cnt_reg == LAT_W'(RD_LAT)) begin
            rsp_data  <= read_data;
            rsp_valid <= 1'b1;
            state_reg <= ST_RESP;
          end else begin
            lat_cnt_reg <= lat_cnt_reg + LAT_W'(1);
          end
        end
        ST_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state_reg <= ST_IDLE;
          end
        end
        default: begin
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_scheduler.sv
module tb_mem_access_scheduler;

  logic       clk_mem;
  logic       reset;
  logic       req_valid;
  logic       req_ready;
  logic       req_write;
  logic [7:0] req_addr;
  logic [7:0] req_wdata;
  logic       w_en;
  logic       r_en;
  logic [7:0] write_data;
  logic [7:0] read_address;
  logic [7:0] read_data;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [7:0] rsp_data;
  logic       busy;

  int vectors    = 0;
  int miscompares = 0;

  logic [7:0] mem_model [256];
  logic [7:0] rsp_log [$];

  mem_access_scheduler #(
    .QDEPTH (4),
    .RD_LAT (1)
  ) dut (
    .clk_mem      (clk_mem),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_write    (req_write),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .w_en         (w_en),
    .r_en         (r_en),
    .write_data   (write_data),
    .read_address (read_address),
    .read_data    (read_data),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_data     (rsp_data),
    .busy         (busy)
  );

  initial clk_mem = 1'b0;
  always #5 clk_mem = ~clk_mem;

  // Memory controller model: one-cycle read latency.
  always @(posedge clk_mem) begin
    if (w_en) mem_model[read_address] <= write_data;
    if (r_en) read_data <= mem_model[read_address];
  end

  // Response collector.
  always @(posedge clk_mem) begin
    if (reset && rsp_valid && rsp_ready) rsp_log.push_back(rsp_data);
  end

  task automatic tick();
    @(posedge clk_mem);
    #1;
  endtask

  task automatic push_req(input logic wr, input logic [7:0] a, input logic [7:0] d);
    logic acc;
    acc = 1'b0;
    req_valid = 1'b1; req_write = wr; req_addr = a; req_wdata = d;
    for (int i = 0; i < 50 && !acc; i++) begin
      acc = req_ready;
      tick();
    end
    req_valid = 1'b0;
    vectors++;
    if (acc !== 1'b1) begin
      miscompares++;
      $display("FAIL push_accept addr=%h: got accepted=%b, want 1", a, acc);
    end
  endtask

  task automatic wait_rsp(input int budget, output logic ok);
    ok = rsp_valid;
    for (int i = 0; i < budget && !ok; i++) begin
      tick();
      ok = rsp_valid;
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
    rsp_ready = 1'b0; read_data = '0;
    #2;
    vectors += 8;
    if (w_en !== 1'b0)         begin miscompares++; $display("FAIL rst_w_en got=%b want=0", w_en); end
    if (r_en !== 1'b0)         begin miscompares++; $display("FAIL rst_r_en got=%b want=0", r_en); end
    if (write_data !== 8'h00)  begin miscompares++; $display("FAIL rst_write_data got=%h want=00", write_data); end
    if (read_address !== 8'h00) begin miscompares++; $display("FAIL rst_read_address got=%h want=00", read_address); end
    if (rsp_valid !== 1'b0)    begin miscompares++; $display("FAIL rst_rsp_valid got=%b want=0", rsp_valid); end
    if (rsp_data !== 8'h00)    begin miscompares++; $display("FAIL rst_rsp_data got=%h want=00", rsp_data); end
    if (busy !== 1'b0)         begin miscompares++; $display("FAIL rst_busy got=%b want=0", busy); end
    if (req_ready !== 1'b1)    begin miscompares++; $display("FAIL rst_req_ready got=%b want=1", req_ready); end
    tick(); tick();
    reset = 1'b1;
    tick();
    $display("test_reset done");
  endtask

  task automatic test_write_read();
    req_valid = 1'b1; req_write = 1'b1; req_addr = 8'h10; req_wdata = 8'hA5;
    tick();
    req_valid = 1'b0;
    vectors++; if (w_en !== 1'b0) begin miscompares++; $display("FAIL wr_lat0 w_en got=%b want=0", w_en); end
    tick();
    vectors += 2;
    if (w_en !== 1'b0) begin miscompares++; $display("FAIL wr_lat1 w_en got=%b want=0", w_en); end
    if (busy !== 1'b1) begin miscompares++; $display("FAIL wr_busy got=%b want=1", busy); end
    tick();
    vectors += 4;
    if (w_en !== 1'b1)          begin miscompares++; $display("FAIL wr_strobe w_en got=%b want=1", w_en); end
    if (r_en !== 1'b0)          begin miscompares++; $display("FAIL wr_strobe r_en got=%b want=0", r_en); end
    if (read_address !== 8'h10) begin miscompares++; $display("FAIL wr_addr got=%h want=10", read_address); end
    if (write_data !== 8'hA5)   begin miscompares++; $display("FAIL wr_data got=%h want=a5", write_data); end
    tick();
    vectors += 2;
    if (w_en !== 1'b0)          begin miscompares++; $display("FAIL wr_pulse_end w_en got=%b want=0", w_en); end
    if (read_address !== 8'h10) begin miscompares++; $display("FAIL wr_addr_hold got=%h want=10", read_address); end

    req_valid = 1'b1; req_write = 1'b0; req_addr = 8'h10; req_wdata = 8'hFF;
    tick();
    req_valid = 1'b0;
    tick();
    vectors++; if (r_en !== 1'b0) begin miscompares++; $display("FAIL rd_lat1 r_en got=%b want=0", r_en); end
    tick();
    vectors += 3;
    if (r_en !== 1'b1)          begin miscompares++; $display("FAIL rd_strobe r_en got=%b want=1", r_en); end
    if (w_en !== 1'b0)          begin miscompares++; $display("FAIL rd_strobe w_en got=%b want=0", w_en); end
    if (read_address !== 8'h10) begin miscompares++; $display("FAIL rd_addr got=%h want=10", read_address); end
    tick();
    vectors += 2;
    if (r_en !== 1'b0)      begin miscompares++; $display("FAIL rd_pulse_end r_en got=%b want=0", r_en); end
    if (rsp_valid !== 1'b0) begin miscompares++; $display("FAIL rd_early_rsp got=%b want=0", rsp_valid); end
    tick();
    vectors += 2;
    if (rsp_valid !== 1'b1) begin miscompares++; $display("FAIL rd_rsp_valid got=%b want=1", rsp_valid); end
    if (rsp_data !== 8'hA5) begin miscompares++; $display("FAIL rd_rsp_data got=%h want=a5", rsp_data); end
    tick();
    vectors++; if (rsp_valid !== 1'b1) begin miscompares++; $display("FAIL rd_rsp_hold got=%b want=1", rsp_valid); end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    vectors++; if (rsp_valid !== 1'b0) begin miscompares++; $display("FAIL rd_rsp_done got=%b want=0", rsp_valid); end
    $display("test_write_read done");
  endtask

  task automatic test_hold();
    logic ok;
    logic seen;
    rsp_ready = 1'b0;
    push_req(1'b1, 8'h20, 8'h3C);
    push_req(1'b0, 8'h20, 8'h00);
    wait_rsp(20, ok);
    vectors += 2;
    if (ok !== 1'b1)        begin miscompares++; $display("FAIL hold_rsp_arrive got=%b want=1", ok); end
    if (rsp_data !== 8'h3C) begin miscompares++; $display("FAIL hold_rsp_data got=%h want=3c", rsp_data); end
    // Queue a write while the response is stalled; it must not issue yet.
    req_valid = 1'b1; req_write = 1'b1; req_addr = 8'h21; req_wdata = 8'h77;
    tick();
    req_valid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      vectors += 3;
      if (rsp_valid !== 1'b1)    begin miscompares++; $display("FAIL hold_valid cyc=%0d got=%b want=1", i, rsp_valid); end
      if (rsp_data !== 8'h3C)    begin miscompares++; $display("FAIL hold_data cyc=%0d got=%h want=3c", i, rsp_data); end
      if ((w_en | r_en) !== 1'b0) begin miscompares++; $display("FAIL hold_strobe cyc=%0d got=%b want=0", i, w_en | r_en); end
      tick();
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    vectors++; if (rsp_valid !== 1'b0) begin miscompares++; $display("FAIL hold_release got=%b want=0", rsp_valid); end
    seen = w_en;
    for (int i = 0; i < 10 && !seen; i++) begin
      tick();
      seen = w_en;
    end
    vectors += 3;
    if (seen !== 1'b1)          begin miscompares++; $display("FAIL hold_next_issue got=%b want=1", seen); end
    if (read_address !== 8'h21) begin miscompares++; $display("FAIL hold_next_addr got=%h want=21", read_address); end
    if (write_data !== 8'h77)   begin miscompares++; $display("FAIL hold_next_data got=%h want=77", write_data); end
    tick();
    $display("test_hold done");
  endtask

  task automatic test_full();
    logic ok;
    int   n;
    rsp_ready = 1'b0;
    push_req(1'b0, 8'h10, 8'h00);
    wait_rsp(20, ok);
    vectors++; if (ok !== 1'b1) begin miscompares++; $display("FAIL full_stall_rsp got=%b want=1", ok); end
    for (int k = 0; k < 4; k++) push_req(1'b1, 8'(8'h30 + k), 8'(8'h40 + k));
    vectors += 2;
    if (req_ready !== 1'b0) begin miscompares++; $display("FAIL full_ready got=%b want=0", req_ready); end
    if (busy !== 1'b1)      begin miscompares++; $display("FAIL full_busy got=%b want=1", busy); end
    req_valid = 1'b1; req_write = 1'b1; req_addr = 8'h34; req_wdata = 8'h44;
    for (int i = 0; i < 3; i++) begin
      vectors++; if (req_ready !== 1'b0) begin miscompares++; $display("FAIL full_block cyc=%0d got=%b want=0", i, req_ready); end
      tick();
    end
    rsp_ready = 1'b1;
    tick();
    vectors++; if (req_ready !== 1'b0) begin miscompares++; $display("FAIL full_no_bypass got=%b want=0", req_ready); end
    tick();
    vectors++; if (req_ready !== 1'b1) begin miscompares++; $display("FAIL full_after_pop got=%b want=1", req_ready); end
    tick();
    req_valid = 1'b0;
    n = 0;
    for (int i = 0; i < 40; i++) begin
      if (w_en === 1'b1) begin
        vectors += 2;
        if (read_address !== 8'(8'h30 + n)) begin miscompares++; $display("FAIL full_order_addr n=%0d got=%h want=%h", n, read_address, 8'(8'h30 + n)); end
        if (write_data !== 8'(8'h40 + n))   begin miscompares++; $display("FAIL full_order_data n=%0d got=%h want=%h", n, write_data, 8'(8'h40 + n)); end
        n++;
      end
      if (w_en === 1'b1 && r_en === 1'b1) begin
        vectors++; miscompares++; $display("FAIL full_excl cyc=%0d got w_en=1 r_en=1 want not both", i);
      end
      tick();
    end
    vectors += 2;
    if (n !== 5)       begin miscompares++; $display("FAIL full_issue_count got=%0d want=5", n); end
    if (busy !== 1'b0) begin miscompares++; $display("FAIL full_drained_busy got=%b want=0", busy); end
    $display("test_full done");
  endtask

  task automatic test_reset_mid();
    int viol;
    rsp_ready = 1'b1;
    push_req(1'b0, 8'h10, 8'h00);
    push_req(1'b1, 8'h50, 8'h01);
    push_req(1'b1, 8'h51, 8'h02);
    push_req(1'b1, 8'h52, 8'h03);
    // FSM is now in WAIT with three writes queued.
    vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL mid_busy_before got=%b want=1", busy); end
    reset = 1'b0;
    #1;
    vectors += 8;
    if (w_en !== 1'b0)          begin miscompares++; $display("FAIL mid_w_en got=%b want=0", w_en); end
    if (r_en !== 1'b0)          begin miscompares++; $display("FAIL mid_r_en got=%b want=0", r_en); end
    if (write_data !== 8'h00)   begin miscompares++; $display("FAIL mid_write_data got=%h want=00", write_data); end
    if (read_address !== 8'h00) begin miscompares++; $display("FAIL mid_read_address got=%h want=00", read_address); end
    if (rsp_valid !== 1'b0)     begin miscompares++; $display("FAIL mid_rsp_valid got=%b want=0", rsp_valid); end
    if (rsp_data !== 8'h00)     begin miscompares++; $display("FAIL mid_rsp_data got=%h want=00", rsp_data); end
    if (busy !== 1'b0)          begin miscompares++; $display("FAIL mid_busy got=%b want=0", busy); end
    if (req_ready !== 1'b1)     begin miscompares++; $display("FAIL mid_req_ready got=%b want=1", req_ready); end
    tick(); tick();
    reset = 1'b1;
    viol = 0;
    for (int i = 0; i < 20; i++) begin
      if (w_en !== 1'b0 || r_en !== 1'b0 || rsp_valid !== 1'b0) viol++;
      tick();
    end
    vectors += 2;
    if (viol !== 0)    begin miscompares++; $display("FAIL mid_post_activity got=%0d want=0", viol); end
    if (busy !== 1'b0) begin miscompares++; $display("FAIL mid_post_busy got=%b want=0", busy); end
    $display("test_reset_mid done");
  endtask

  task automatic test_wrap();
    rsp_ready = 1'b1;
    rsp_log.delete();
    for (int i = 0; i < 6; i++) begin
      push_req(1'b1, 8'(i), 8'(8'hC0 + i));
      push_req(1'b0, 8'(i), 8'h00);
    end
    for (int i = 0; i < 100 && rsp_log.size() < 6; i++) tick();
    vectors++;
    if (rsp_log.size() !== 6) begin
      miscompares++; $display("FAIL wrap_rsp_count got=%0d want=6", rsp_log.size());
    end else begin
      for (int i = 0; i < 6; i++) begin
        vectors++;
        if (rsp_log[i] !== 8'(8'hC0 + i)) begin miscompares++; $display("FAIL wrap_rsp_data idx=%0d got=%h want=%h", i, rsp_log[i], 8'(8'hC0 + i)); end
      end
    end
    tick(); tick();
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL wrap_busy got=%b want=0", busy); end
    $display("test_wrap done");
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_hold();
    test_full();
    test_reset_mid();
    test_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
